// File: rtl/ser_rx_fifo_param.sv
// Oversampled asynchronous serial receiver (5..9 data bits, optional parity, 1/2 stop bits)
// feeding a first-word-fall-through receive FIFO; all state advances only when enn=1.
module ser_rx_fifo_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          init_n,
  input  logic                          enn,
  input  logic                          baudTick,
  input  logic                          SID,
  input  logic                          parEn,
  input  logic                          parOdd,
  input  logic                          twoStop,
  input  logic                          rdStb,
  output logic [DATA_BITS-1:0]          Dr,
  output logic                          rxValid,
  output logic [$clog2(FIFO_DEPTH):0]   rxCount,
  output logic                          sdiBusy,
  output logic                          setFramerr,
  output logic                          setParerr,
  output logic                          setOverrun
);

  // state     | meaning
  // S_IDLE    | line idle, waiting for synchronised SID low
  // S_START   | half-bit wait, then confirm start bit (high = false start)
  // S_DATA    | mid-bit samples of the data bits, LSB first
  // S_PARITY  | mid-bit sample of the parity bit
  // S_STOP1   | first stop bit sample
  // S_STOP2   | second stop bit sample
  // S_WAIT_HI | after a framing error, hold until the line returns high
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HI
  } state_t;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] HALF_LD = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LD = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LD = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);

  logic                 sid_meta, sid_s;
  state_t               state, state_nxt;
  logic                 tick, tc;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 cfg_par_en, cfg_par_odd, cfg_two_stop;
  logic                 par_bad, stop_bad;
  logic                 ld_half, ld_full, ld_bits, shift_en, par_smp, stop_smp, finish, frame_bad;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, empty, pop, push;

  assign tick  = enn & baudTick;
  assign tc    = (tick_cnt == '0);
  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign pop   = enn & rdStb & ~empty;
  // a pop in the same cycle frees the slot the finishing word needs
  assign push  = finish & (~full | pop);

  always_ff @(posedge clk) begin
    if (!init_n) begin
      sid_meta <= 1'b1;
      sid_s    <= 1'b1;
    end else begin
      sid_meta <= SID;
      sid_s    <= sid_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_half   = 1'b0;
    ld_full   = 1'b0;
    ld_bits   = 1'b0;
    shift_en  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    finish    = 1'b0;
    frame_bad = stop_bad | ~sid_s;
    case (state)
      S_IDLE: begin
        if (tick && !sid_s) begin
          state_nxt = S_START;
          ld_half   = 1'b1;
        end
      end
      S_START: begin
        if (tick && tc) begin
          if (!sid_s) begin
            state_nxt = S_DATA;
            ld_full   = 1'b1;
            ld_bits   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick && tc) begin
          shift_en = 1'b1;
          ld_full  = 1'b1;
          if (bit_cnt == '0) state_nxt = cfg_par_en ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (tick && tc) begin
          par_smp   = 1'b1;
          ld_full   = 1'b1;
          state_nxt = S_STOP1;
        end
      end
      S_STOP1: begin
        if (tick && tc) begin
          stop_smp = 1'b1;
          if (cfg_two_stop) begin
            ld_full   = 1'b1;
            state_nxt = S_STOP2;
          end else begin
            finish    = 1'b1;
            state_nxt = frame_bad ? S_WAIT_HI : S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (tick && tc) begin
          stop_smp  = 1'b1;
          finish    = 1'b1;
          state_nxt = frame_bad ? S_WAIT_HI : S_IDLE;
        end
      end
      S_WAIT_HI: begin
        if (tick && sid_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      cfg_par_en   <= 1'b0;
      cfg_par_odd  <= 1'b0;
      cfg_two_stop <= 1'b0;
      par_bad      <= 1'b0;
      stop_bad     <= 1'b0;
      setFramerr   <= 1'b0;
      setParerr    <= 1'b0;
      setOverrun   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      setFramerr <= finish & frame_bad;
      setParerr  <= finish & cfg_par_en & par_bad;
      setOverrun <= finish & full & ~pop;

      // frame format is frozen at start-bit detection
      if (ld_half) begin
        tick_cnt     <= HALF_LD;
        cfg_par_en   <= parEn;
        cfg_par_odd  <= parOdd;
        cfg_two_stop <= twoStop;
        par_bad      <= 1'b0;
        stop_bad     <= 1'b0;
      end else if (ld_full) begin
        tick_cnt <= FULL_LD;
      end else if (tick && !tc) begin
        tick_cnt <= tick_cnt - TW'(1);
      end

      if (ld_bits)       bit_cnt <= BITS_LD;
      else if (shift_en) bit_cnt <= bit_cnt - BW'(1);

      if (shift_en) shreg    <= {sid_s, shreg[DATA_BITS-1:1]};
      if (par_smp)  par_bad  <= (((^shreg) ^ sid_s) != cfg_par_odd);
      if (stop_smp) stop_bad <= frame_bad;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init_n && push) mem[wr_ptr] <= shreg;
  end

  assign Dr      = empty ? '0 : mem[rd_ptr];
  assign rxValid = ~empty;
  assign rxCount = count;
  assign sdiBusy = (state != S_IDLE) && (state != S_WAIT_HI);

endmodule

// File: tb/tb_ser_rx_fifo_param.sv
// Scoreboard bench for ser_rx_fifo_param: the stimulus side predicts each frame outcome and each
// FIFO pop from a queue model; an independent monitor compares as the DUT reports them.
`timescale 1ns/1ps
module tb_ser_rx_fifo_param;
  localparam int DB = 8;
  localparam int FD = 4;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic init_n = 1'b0, enn = 1'b0, baudTick = 1'b1, SID = 1'b1;
  logic parEn = 1'b0, parOdd = 1'b0, twoStop = 1'b0, rdStb = 1'b0;
  logic [DB-1:0]        Dr;
  logic                 rxValid;
  logic [$clog2(FD):0]  rxCount;
  logic                 sdiBusy, setFramerr, setParerr, setOverrun;

  typedef struct {logic fe; logic pe; logic ov; int cnt;} frm_t;
  typedef struct {logic v; logic [DB-1:0] d; int cnt;} pop_t;

  frm_t          exp_frm[$];
  pop_t          exp_pop[$];
  logic [DB-1:0] model_q[$];
  int            checks = 0;
  int            errors = 0;

  ser_rx_fifo_param #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .OVERSAMPLE(OS)) dut (
    .clk(clk), .init_n(init_n), .enn(enn), .baudTick(baudTick), .SID(SID),
    .parEn(parEn), .parOdd(parOdd), .twoStop(twoStop), .rdStb(rdStb),
    .Dr(Dr), .rxValid(rxValid), .rxCount(rxCount), .sdiBusy(sdiBusy),
    .setFramerr(setFramerr), .setParerr(setParerr), .setOverrun(setOverrun)
  );

  always #5 clk = ~clk;

  initial begin : enn_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      enn = (ph == 0);
      ph  = (ph + 1) % 3;
    end
  end

  initial begin : watchdog
    #900_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  task automatic wait_tick();
    do @(posedge clk); while (!(enn && baudTick));
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic expect_pop();
    pop_t p;
    p.cnt = model_q.size();
    if (model_q.size() == 0) begin
      p.v = 1'b0;
      p.d = '0;
    end else begin
      p.v = 1'b1;
      p.d = model_q.pop_front();
    end
    exp_pop.push_back(p);
  endtask

  task automatic do_pop();
    expect_pop();
    rdStb = 1'b1;
    wait_tick();
    rdStb = 1'b0;
  endtask

  task automatic frame_done(input bit fe, input bit pe, input logic [DB-1:0] w);
    frm_t f;
    f.fe = fe;
    f.pe = pe;
    if (model_q.size() < FD) begin
      model_q.push_back(w);
      f.ov = 1'b0;
    end else begin
      f.ov = 1'b1;
    end
    f.cnt = model_q.size();
    exp_frm.push_back(f);
  endtask

  // line-level frame: start, data LSB first, optional parity, stop bit(s)
  task automatic send_frame(input logic [DB-1:0] d, input bit pe_en, input bit podd, input bit two,
                            input bit pbit, input bit s1, input bit s2, input bit pop_fin,
                            input bit scramble, input int hold_low, input int gap);
    bit bits[$];
    bit fe, pe;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (pe_en) bits.push_back(pbit);
    bits.push_back(s1);
    if (two) bits.push_back(s2);
    fe = !s1 || (two && !s2);
    pe = pe_en && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
    parEn = pe_en; parOdd = podd; twoStop = two;
    foreach (bits[i]) begin
      SID = bits[i];
      if (i == 1 && scramble) begin
        parEn = 1'($urandom); parOdd = 1'($urandom); twoStop = 1'($urandom);
      end
      if (i == bits.size() - 1) begin
        wait_ticks(OS / 2);
        if (pop_fin) begin
          expect_pop();
          rdStb = 1'b1;
        end
        wait_tick();
        rdStb = 1'b0;
        frame_done(fe, pe, d);
        wait_ticks(OS / 2 - 1);
      end else begin
        wait_ticks(OS);
      end
    end
    if (hold_low > 0) wait_ticks(hold_low);
    SID = 1'b1;
    wait_ticks(gap);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_Dr"},         32'(Dr),         32'(0));
    chk({tag, "_rxValid"},    32'(rxValid),    32'(0));
    chk({tag, "_rxCount"},    32'(rxCount),    32'(0));
    chk({tag, "_sdiBusy"},    32'(sdiBusy),    32'(0));
    chk({tag, "_setFramerr"}, 32'(setFramerr), 32'(0));
    chk({tag, "_setParerr"},  32'(setParerr),  32'(0));
    chk({tag, "_setOverrun"}, 32'(setOverrun), 32'(0));
  endtask

  initial begin : monitor
    bit   prev_busy;
    frm_t f;
    pop_t p;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!init_n) begin
        prev_busy = 1'b0;
        continue;
      end
      if (enn && rdStb) begin
        if (exp_pop.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop: got rdStb pop required none");
        end else begin
          p = exp_pop.pop_front();
          chk("pop_rxValid", 32'(rxValid), 32'(p.v));
          chk("pop_Dr",      32'(Dr),      32'(p.d));
          chk("pop_rxCount", 32'(rxCount), 32'(p.cnt));
        end
      end
      if (prev_busy && !sdiBusy) begin
        if (exp_frm.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_end: got sdiBusy fall required none");
        end else begin
          f = exp_frm.pop_front();
          chk("frame_setFramerr", 32'(setFramerr), 32'(f.fe));
          chk("frame_setParerr",  32'(setParerr),  32'(f.pe));
          chk("frame_setOverrun", 32'(setOverrun), 32'(f.ov));
          chk("frame_rxCount",    32'(rxCount),    32'(f.cnt));
        end
      end else if (setFramerr || setParerr || setOverrun) begin
        checks++; errors++;
        $display("FAIL stray_pulse: got fe=%0b pe=%0b ov=%0b required 000",
                 setFramerr, setParerr, setOverrun);
      end
      prev_busy = sdiBusy;
    end
  end

  initial begin : stim
    frm_t fs;
    int   np;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    init_n = 1'b1;
    wait_ticks(4);

    // reset in the middle of a frame
    SID = 1'b0; wait_ticks(OS);
    SID = 1'b1; wait_ticks(OS);
    SID = 1'b0; wait_ticks(5);
    chk("midframe_busy", 32'(sdiBusy), 32'(1));
    init_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("midreset");
    model_q.delete();
    init_n = 1'b1;
    SID = 1'b1;
    wait_ticks(4);
    send_frame(8'hA5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4);
    do_pop();

    // 8N1 0x4B
    send_frame(8'h4B, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4);
    chk("8n1_Dr",      32'(Dr),      32'(8'h4B));
    chk("8n1_rxValid", 32'(rxValid), 32'(1));
    chk("8n1_rxCount", 32'(rxCount), 32'(1));
    chk("8n1_busy",    32'(sdiBusy), 32'(0));

    // even parity, 0x61 with parity bit 0 -> mismatch
    send_frame(8'h61, 1, 0, 0, 0, 1, 1, 0, 0, 0, 4);
    do_pop(); do_pop();

    // break: stop bit low then line low for 40 bit times
    send_frame(8'h3C, 0, 0, 0, 0, 0, 1, 0, 0, 40 * OS, 4);
    chk("break_rxCount", 32'(rxCount), 32'(1));
    chk("break_busy",    32'(sdiBusy), 32'(0));
    do_pop();

    // false start: low for 4 ticks only
    fs.fe = 0; fs.pe = 0; fs.ov = 0; fs.cnt = model_q.size();
    exp_frm.push_back(fs);
    SID = 1'b0; wait_ticks(4);
    SID = 1'b1; wait_ticks(2 * OS);

    // overrun on the fifth word, then drain past empty
    for (int i = 1; i <= 5; i++) send_frame(DB'(i), 0, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    chk("ovr_rxCount", 32'(rxCount), 32'(FD));
    for (int i = 0; i < 5; i++) do_pop();
    chk("drain_rxValid", 32'(rxValid), 32'(0));
    chk("drain_Dr",      32'(Dr),      32'(0));

    // push and pop on the same cycle while full
    for (int i = 0; i < FD; i++) send_frame(DB'(8'h11 + i), 0, 0, 1, 0, 1, 1, 0, 0, 0, 3);
    send_frame(8'h15, 1, 1, 1, 1, 1, 1, 1, 0, 0, 3);
    for (int i = 0; i < FD; i++) do_pop();

    // randomised frames, formats, errors and pops
    for (int n = 0; n < 30; n++) begin
      send_frame(DB'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0), 1'($urandom), 0, $urandom_range(2, 20));
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) do_pop();
    end
    for (int i = 0; i <= FD; i++) do_pop();
    wait_ticks(8);
    chk("pending_frames", 32'(exp_frm.size()), 32'(0));
    chk("pending_pops",   32'(exp_pop.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
